audio_tone_source: RTL and testbench

- Stereo square-wave sample generator sitting directly upstream of the audio controller's DAC streaming inputs; drives the to_dac_left/right ready/valid channels.
- Produces one left/right sample pair per handshake; the waveform is paced purely by sample acceptance, so the output frequency equals the DAC sample rate / (2*half_period).
- Used for codec bring-up and as a test tone when no ADC loopback is active.

---
 rtl/audio_tone_source.sv | 93 +++++++++
 tb/tb_audio_tone_source.sv | 135 +++++++++++++
 2 files changed

// File: rtl/audio_tone_source.sv
// Stereo square-wave source for the DAC streaming channels: one L/R pair per handshake,
// toggling sign every half_period accepted pairs.
module audio_tone_source #(
  parameter int DATA_WIDTH = 16,
  parameter int HP_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [HP_WIDTH-1:0]   half_period,
  input  logic [DATA_WIDTH-1:0] left_amplitude,
  input  logic [DATA_WIDTH-1:0] right_amplitude,
  output logic [DATA_WIDTH-1:0] to_dac_left_channel_data,
  output logic                  to_dac_left_channel_valid,
  input  logic                  to_dac_left_channel_ready,
  output logic [DATA_WIDTH-1:0] to_dac_right_channel_data,
  output logic                  to_dac_right_channel_valid,
  input  logic                  to_dac_right_channel_ready,
  output logic                  tone_phase
);
  localparam int MW = DATA_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t                       state;
  logic [HP_WIDTH-1:0]          cnt, hp_q;
  logic [1:0][MW-1:0]           amp_q, amp_in, amp_sel;
  logic [1:0][DATA_WIDTH-1:0]   data_q, sample;
  logic [1:0]                   vld, done, rdy, xfer;
  logic                         pair_done, wrap;
  logic                         unused_amp_msb;

  // Index 0 = left, 1 = right; amplitude MSB is dropped to keep a 15-bit magnitude.
  assign amp_in         = {right_amplitude[MW-1:0], left_amplitude[MW-1:0]};
  assign unused_amp_msb = left_amplitude[MW] ^ right_amplitude[MW];
  assign rdy            = {to_dac_right_channel_ready, to_dac_left_channel_ready};
  assign xfer           = done | (vld & rdy);
  assign pair_done      = &xfer;
  assign wrap           = (cnt == hp_q - HP_WIDTH'(1));
  // Config is only picked up at the first sample of a half-cycle.
  assign amp_sel        = (cnt == '0) ? amp_in : amp_q;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    assign sample[i] = tone_phase ? {1'b0, amp_sel[i]}
                                  : DATA_WIDTH'(0) - {1'b0, amp_sel[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vld        <= '0;
      done       <= '0;
      data_q     <= '0;
      tone_phase <= 1'b1;
      cnt        <= '0;
      hp_q       <= HP_WIDTH'(1);
      amp_q      <= '0;
    end else begin
      case (state)
        IDLE: if (enable) state <= LOAD;
        LOAD: begin
          if (cnt == '0) begin
            hp_q  <= (half_period == '0) ? HP_WIDTH'(1) : half_period;
            amp_q <= amp_in;
          end
          data_q <= sample;
          vld    <= 2'b11;
          done   <= '0;
          state  <= SEND;
        end
        SEND: begin
          vld  <= vld & ~rdy;
          done <= xfer;
          if (pair_done) begin
            if (wrap) begin
              cnt        <= '0;
              tone_phase <= ~tone_phase;
            end else begin
              cnt <= cnt + HP_WIDTH'(1);
            end
            state <= enable ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign to_dac_left_channel_data   = data_q[0];
  assign to_dac_right_channel_data  = data_q[1];
  assign to_dac_left_channel_valid  = vld[0];
  assign to_dac_right_channel_valid = vld[1];
endmodule

// File: tb/tb_audio_tone_source.sv
// Directed cycle-exact bench for audio_tone_source; expected samples computed by hand.
module tb_audio_tone_source;
  logic        clk = 1'b0;
  logic        reset, enable;
  logic [15:0] half_period, left_amplitude, right_amplitude;
  logic [15:0] dl, dr;
  logic        vl, vr, rl, rr, phase;
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  audio_tone_source #(.DATA_WIDTH(16), .HP_WIDTH(16)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .enable                     (enable),
    .half_period                (half_period),
    .left_amplitude             (left_amplitude),
    .right_amplitude            (right_amplitude),
    .to_dac_left_channel_data   (dl),
    .to_dac_left_channel_valid  (vl),
    .to_dac_left_channel_ready  (rl),
    .to_dac_right_channel_data  (dr),
    .to_dac_right_channel_valid (vr),
    .to_dac_right_channel_ready (rr),
    .tone_phase                 (phase)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pair with both readys high: a LOAD cycle (valids low), then valids high with data.
  task automatic pair(input string tag, input logic [15:0] el, input logic [15:0] er,
                      input logic ep);
    tick();
    chk({tag, "/vl_lo"}, vl, 0);
    chk({tag, "/vr_lo"}, vr, 0);
    tick();
    chk({tag, "/vl"}, vl, 1);
    chk({tag, "/vr"}, vr, 1);
    chk({tag, "/dl"}, dl, el);
    chk({tag, "/dr"}, dr, er);
    chk({tag, "/ph"}, phase, ep);
  endtask

  initial begin
    reset = 1; enable = 0; half_period = 16'd2;
    left_amplitude = 16'h1000; right_amplitude = 16'h1000; rl = 1; rr = 1;
    tick(); tick();
    chk("rst/vl", vl, 0); chk("rst/vr", vr, 0);
    chk("rst/dl", dl, 0); chk("rst/dr", dr, 0); chk("rst/ph", phase, 1);
    reset = 0;
    tick();
    chk("idle/vl", vl, 0);

    // Basic square wave, half_period 2
    enable = 1;
    pair("a1", 16'h1000, 16'h1000, 1);
    pair("a2", 16'h1000, 16'h1000, 1);
    pair("a3", 16'hF000, 16'hF000, 0);
    pair("a4", 16'hF000, 16'hF000, 0);
    pair("a5", 16'h1000, 16'h1000, 1);

    // Left stalls 5 cycles, right accepts immediately
    rl = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b/vl", vl, 1); chk("b/dl", dl, 16'h1000);
      chk("b/vr", vr, 0); chk("b/ph", phase, 1);
    end
    rl = 1;
    pair("b6", 16'h1000, 16'h1000, 1);
    pair("b7", 16'hF000, 16'hF000, 0);

    // half_period 0 acts as 1; right amplitude MSB ignored
    half_period = 16'd0; left_amplitude = 16'h7FFF; right_amplitude = 16'hFFFF;
    pair("c8",  16'hF000, 16'hF000, 0);
    pair("c9",  16'h7FFF, 16'h7FFF, 1);
    pair("c10", 16'h8001, 16'h8001, 0);
    pair("c11", 16'h7FFF, 16'h7FFF, 1);

    // Config change mid half-cycle
    half_period = 16'd3; left_amplitude = 16'h0100; right_amplitude = 16'h0100;
    pair("d12", 16'hFF00, 16'hFF00, 0);
    half_period = 16'd1; left_amplitude = 16'h0200;
    pair("d13", 16'hFF00, 16'hFF00, 0);
    pair("d14", 16'hFF00, 16'hFF00, 0);
    pair("d15", 16'h0200, 16'h0100, 1);
    pair("d16", 16'hFE00, 16'hFF00, 0);

    // Drop enable with right still pending
    rr = 0;
    tick();
    chk("e/vl0", vl, 0); chk("e/vr0", vr, 1); chk("e/dr0", dr, 16'hFF00);
    enable = 0;
    tick();
    chk("e/vr1", vr, 1); chk("e/ph1", phase, 0);
    rr = 1;
    tick();
    chk("e/vl2", vl, 0); chk("e/vr2", vr, 0); chk("e/ph2", phase, 1);
    tick(); tick();
    chk("e/idle_vl", vl, 0); chk("e/idle_vr", vr, 0);
    enable = 1;
    pair("e17", 16'h0200, 16'h0100, 1);
    pair("e18", 16'hFE00, 16'hFF00, 0);

    // Reset mid-SEND with valids high
    rl = 0; rr = 0; reset = 1;
    half_period = 16'd2; left_amplitude = 16'h1000; right_amplitude = 16'h1000;
    tick();
    chk("f/vl", vl, 0); chk("f/vr", vr, 0);
    chk("f/dl", dl, 0); chk("f/dr", dr, 0); chk("f/ph", phase, 1);
    reset = 0; rl = 1; rr = 1;
    pair("f19", 16'h1000, 16'h1000, 1);
    pair("f20", 16'h1000, 16'h1000, 1);
    pair("f21", 16'hF000, 16'hF000, 0);

    // Zero amplitude still handshakes
    left_amplitude = 16'h0000; right_amplitude = 16'h8000;
    pair("g22", 16'hF000, 16'hF000, 0);
    pair("g23", 16'h0000, 16'h0000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
